// File: rtl/stage1_assemble_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage1_assemble_module: packs byte-serial messages MSB-first into three  |
// | 264-bit lanes and emits them as a group. Optional: STAGE1_MSG_COUNT_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stage1_assemble_module #(
  parameter int DATA_BYTES   = 33,
  parameter int IDLE_TIMEOUT = 255,
  parameter int CNT_BITS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    byte_last,
  input  logic                    flush,
  output logic                    message_en_out,
  output logic [2:0]              lane_valid,
  output logic [DATA_BYTES*8-1:0] original_data_1,
  output logic [DATA_BYTES*8-1:0] original_data_2,
  output logic [DATA_BYTES*8-1:0] original_data_3,
  output logic                    overflow_err
`ifdef STAGE1_MSG_COUNT_EN
  ,
  output logic [31:0]             msg_cnt,
  output logic [31:0]             drop_cnt
`endif
);

  localparam int W    = DATA_BYTES * 8;
  localparam int BC_W = $clog2(DATA_BYTES + 1);
  localparam logic [BC_W-1:0]   BC_MAX = BC_W'(DATA_BYTES);
  localparam logic [CNT_BITS:0] TO_VAL = (CNT_BITS + 1)'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lane_idx_q, lane_idx_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [CNT_BITS-1:0] idle_cnt_q, idle_cnt_d;
  logic [W-1:0]        lane_buf_q [3];
  logic [W-1:0]        lane_buf_d [3];
  logic [W-1:0]        out_data_q [3];
  logic [W-1:0]        out_data_d [3];
  logic [2:0]          lane_valid_q, lane_valid_d;
  logic                msg_en_q, msg_en_d;
  logic                ovf_q, ovf_d;

  logic                start;
  logic                in_msg;
  logic                ovf_hit;
  logic                lane_done;
  logic                drop_end;
  logic                emit;
  logic [1:0]          emit_n;
  logic [BC_W-1:0]     eff_cnt;
  logic [CNT_BITS:0]   idle_next;

`ifdef STAGE1_MSG_COUNT_EN
  logic [31:0]         msg_cnt_q, msg_cnt_d;
  logic [31:0]         drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    lane_buf_d   = lane_buf_q;
    out_data_d   = out_data_q;
    lane_valid_d = lane_valid_q;
    msg_en_d     = 1'b0;
    ovf_d        = 1'b0;
    emit         = 1'b0;
    emit_n       = 2'd0;

    start     = byte_valid && (state_q == S_IDLE || state_q == S_WAIT);
    in_msg    = byte_valid && (start || state_q == S_FILL);
    eff_cnt   = start ? '0 : byte_cnt_q;
    ovf_hit   = in_msg && (eff_cnt == BC_MAX);
    lane_done = in_msg && byte_last && !ovf_hit;
    drop_end  = byte_valid && byte_last && (ovf_hit || state_q == S_DROP);
    idle_next = {1'b0, idle_cnt_q} + (CNT_BITS + 1)'(1);

    // A new message clears its lane so unwritten tail bytes read as zero.
    if (start) begin
      lane_buf_d[lane_idx_q] = '0;
    end
    if (in_msg && !ovf_hit) begin
      lane_buf_d[lane_idx_q][W - 1 - 8 * int'(eff_cnt) -: 8] = byte_in;
    end

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (byte_valid) begin
          state_d    = S_FILL;
          byte_cnt_d = BC_W'(1);
        end
      end
      S_FILL: begin
        if (byte_valid) begin
          if (ovf_hit) begin
            if (byte_last) begin
              state_d = (lane_idx_q != 2'd0) ? S_WAIT : S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (byte_valid && byte_last) begin
          state_d = (lane_idx_q != 2'd0) ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lane_done) begin
      byte_cnt_d = '0;
      if (lane_idx_q == 2'd2) begin
        emit   = 1'b1;
        emit_n = 2'd3;
      end else begin
        lane_idx_d = lane_idx_q + 2'd1;
        state_d    = S_WAIT;
      end
    end

    // The idle timer only runs while completed lanes wait for more traffic.
    if (state_q == S_WAIT && !byte_valid) begin
      if (IDLE_TIMEOUT != 0) begin
        idle_cnt_d = idle_next[CNT_BITS-1:0];
        if (idle_next == TO_VAL) begin
          emit   = 1'b1;
          emit_n = lane_idx_q;
        end
      end
    end else begin
      idle_cnt_d = '0;
    end

    ovf_d = drop_end;

    // Flush acts after the current byte, so a just-finished lane is included.
    if (flush) begin
      emit_n     = lane_done ? (lane_idx_q + 2'd1) : lane_idx_q;
      emit       = (emit_n != 2'd0);
      ovf_d      = 1'b0;
      byte_cnt_d = '0;
    end

    if (emit || flush) begin
      state_d    = S_IDLE;
      lane_idx_d = 2'd0;
      idle_cnt_d = '0;
    end

    if (emit) begin
      msg_en_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        out_data_d[k] = (k < int'(emit_n)) ? lane_buf_d[k] : '0;
      end
      case (emit_n)
        2'd1:    lane_valid_d = 3'b001;
        2'd2:    lane_valid_d = 3'b011;
        2'd3:    lane_valid_d = 3'b111;
        default: lane_valid_d = 3'b000;
      endcase
    end
  end

`ifdef STAGE1_MSG_COUNT_EN
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (emit) begin
      msg_cnt_d = msg_cnt_q + {30'd0, emit_n};
    end
    if (ovf_d) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign msg_cnt  = msg_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lane_idx_q   <= 2'd0;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      lane_buf_q   <= '{default: '0};
      out_data_q   <= '{default: '0};
      lane_valid_q <= 3'b000;
      msg_en_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      lane_buf_q   <= lane_buf_d;
      out_data_q   <= out_data_d;
      lane_valid_q <= lane_valid_d;
      msg_en_q     <= msg_en_d;
      ovf_q        <= ovf_d;
    end
  end

  assign message_en_out  = msg_en_q;
  assign lane_valid      = lane_valid_q;
  assign original_data_1 = out_data_q[0];
  assign original_data_2 = out_data_q[1];
  assign original_data_3 = out_data_q[2];
  assign overflow_err    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stage1_assemble_module.sv
`default_nettype none
// Bench for stage1_assemble_module: directed plan steps, then random traffic
// compared every cycle against a message-level reference model.
module tb_stage1_assemble_module;

  localparam int TO = 16;
  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst, byte_valid, byte_last, flush;
  logic [7:0]   byte_in;
  logic         message_en_out, overflow_err;
  logic [2:0]   lane_valid;
  logic [263:0] original_data_1, original_data_2, original_data_3;
`ifdef STAGE1_MSG_COUNT_EN
  logic [31:0]  msg_cnt, drop_cnt;
`endif

  stage1_assemble_module #(.DATA_BYTES(33), .IDLE_TIMEOUT(TO), .CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .flush(flush), .message_en_out(message_en_out),
    .lane_valid(lane_valid), .original_data_1(original_data_1),
    .original_data_2(original_data_2), .original_data_3(original_data_3),
    .overflow_err(overflow_err)
`ifdef STAGE1_MSG_COUNT_EN
    , .msg_cnt(msg_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: open message contents, completed lanes, idle time.
  bit           m_open, m_drop;
  int           m_nl, m_len, m_idle;
  logic [263:0] m_cur;
  logic [263:0] m_lanes [3];
  logic         e_en, e_ovf;
  logic [2:0]   e_valid;
  logic [263:0] e_d [3];
  logic [31:0]  e_msg, e_drop;

  int checks = 0, errors = 0, cycle = 0, n_en = 0, n_ovf = 0;
  int n, np, pc[4];
  int len, gap, fpos;
  bq_t msg;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_drop = 0; m_nl = 0; m_len = 0; m_idle = 0; m_cur = '0;
    for (int k = 0; k < 3; k++) begin m_lanes[k] = '0; e_d[k] = '0; end
    e_en = 0; e_ovf = 0; e_valid = 3'b000; e_msg = 0; e_drop = 0;
  endtask

  task automatic model_emit();
    e_en = 1;
    e_valid = 3'((1 << m_nl) - 1);
    for (int k = 0; k < 3; k++) e_d[k] = (k < m_nl) ? m_lanes[k] : '0;
    e_msg += 32'(m_nl);
    m_nl = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit bl, input bit fl);
    bit ovf_evt;
    ovf_evt = 0;
    e_en = 0;
    if (bv) begin
      m_idle = 0;
      if (m_drop) begin
        if (bl) begin m_drop = 0; ovf_evt = 1; end
      end else begin
        if (!m_open) begin m_open = 1; m_len = 0; m_cur = '0; end
        if (m_len == 33) begin
          m_open = 0;
          if (bl) ovf_evt = 1; else m_drop = 1;
        end else begin
          m_cur[263 - 8*m_len -: 8] = b;
          m_len++;
          if (bl) begin m_lanes[m_nl] = m_cur; m_nl++; m_open = 0; end
        end
      end
    end else if (!m_open && !m_drop && m_nl > 0) begin
      m_idle++;
    end
    if (fl) begin
      if (m_nl > 0) model_emit();
      m_open = 0; m_drop = 0; ovf_evt = 0; m_nl = 0; m_idle = 0;
    end else if (m_nl == 3) begin
      model_emit();
    end else if (!m_open && !m_drop && m_nl > 0 && m_idle == TO) begin
      model_emit();
    end
    e_ovf = ovf_evt;
    if (ovf_evt) e_drop++;
  endtask

  task automatic tick(input bit bv, input logic [7:0] b, input bit bl, input bit fl);
    byte_valid = bv; byte_in = b; byte_last = bl; flush = fl;
    if (rst) model_reset(); else model_step(bv, b, bl, fl);
    @(posedge clk);
    #1;
    cycle++;
    if (message_en_out) n_en++;
    if (overflow_err) n_ovf++;
    chk("message_en_out", 264'(message_en_out), 264'(e_en));
    chk("overflow_err", 264'(overflow_err), 264'(e_ovf));
    chk("lane_valid", 264'(lane_valid), 264'(e_valid));
    chk("original_data_1", original_data_1, e_d[0]);
    chk("original_data_2", original_data_2, e_d[1]);
    chk("original_data_3", original_data_3, e_d[2]);
`ifdef STAGE1_MSG_COUNT_EN
    chk("msg_cnt", 264'(msg_cnt), 264'(e_msg));
    chk("drop_cnt", 264'(drop_cnt), 264'(e_drop));
`endif
  endtask

  task automatic do_reset();
    rst = 1;
    tick(0, 8'h00, 0, 0);
    rst = 0;
  endtask

  task automatic send(input bq_t m);
    for (int i = 0; i < m.size(); i++) tick(1, m[i], i == m.size() - 1, 0);
  endtask

  initial begin
    rst = 0; byte_valid = 0; byte_last = 0; flush = 0; byte_in = 8'h00;
    model_reset();
    do_reset();
    chk("reset_en", 264'(message_en_out), 264'(0));
    chk("reset_valid", 264'(lane_valid), 264'(0));
    chk("reset_data_1", original_data_1, 264'(0));

    // Three messages form one full group
    send('{8'h41, 8'h4E, 8'h4E, 8'hFF});
    send('{8'h41, 8'h4E, 8'h53});
    send('{8'h00});
    chk("t1_en", 264'(message_en_out), 264'(1));
    chk("t1_valid", 264'(lane_valid), 264'(3'b111));
    chk("t1_d1_hi", 264'(original_data_1[263:232]), 264'(32'h414E4EFF));
    chk("t1_d1_lo", 264'(original_data_1[231:0]), 264'(0));
    chk("t1_d2_hi", 264'(original_data_2[263:240]), 264'(24'h414E53));
    chk("t1_d2_lo", 264'(original_data_2[239:0]), 264'(0));
    chk("t1_d3", original_data_3, 264'(0));
    tick(0, 8'h00, 0, 0);
    chk("t1_en_drop", 264'(message_en_out), 264'(0));

    // Overlength message is dropped and does not take a lane
    do_reset();
    n = n_en; np = n_ovf;
    msg = {};
    for (int i = 0; i < 34; i++) msg.push_back(8'(i + 1));
    send(msg);
    send('{8'hAB, 8'hCD});
    tick(0, 8'h00, 0, 0);
    chk("t2_ovf_pulses", 264'(n_ovf - np), 264'(1));
    chk("t2_no_emit", 264'(n_en - n), 264'(0));
    send('{8'h01});
    send('{8'h02});
    chk("t2_valid", 264'(lane_valid), 264'(3'b111));
    chk("t2_d1", 264'(original_data_1[263:248]), 264'(16'hABCD));

    // Idle timeout emits a partial group
    do_reset();
    send('{8'h55, 8'h55});
    n = 0;
    while (!message_en_out && n < 40) begin tick(0, 8'h00, 0, 0); n++; end
    chk("t3_idle_cycles", 264'(n), 264'(TO));
    chk("t3_valid", 264'(lane_valid), 264'(3'b001));
    chk("t3_d1", 264'(original_data_1[263:248]), 264'(16'h5555));
    chk("t3_d2", original_data_2, 264'(0));
    chk("t3_d3", original_data_3, 264'(0));

    // Flush with an open third message
    do_reset();
    send('{8'h10, 8'h11});
    send('{8'h20});
    tick(1, 8'h30, 0, 0); tick(1, 8'h31, 0, 0); tick(1, 8'h32, 0, 0);
    tick(0, 8'h00, 0, 1);
    chk("t4_en", 264'(message_en_out), 264'(1));
    chk("t4_valid", 264'(lane_valid), 264'(3'b011));
    chk("t4_d3", original_data_3, 264'(0));
    send('{8'h77}); send('{8'h88}); send('{8'h99});
    chk("t4_d1_next", 264'(original_data_1[263:256]), 264'(8'h77));

    // Reset mid-message
    send('{8'h11});
    tick(1, 8'h21, 0, 0); tick(1, 8'h22, 0, 0);
    do_reset();
    chk("t5_valid", 264'(lane_valid), 264'(0));
    chk("t5_d1", original_data_1, 264'(0));
    send('{8'hA1}); send('{8'hA2, 8'hA3}); send('{8'hA4});
    chk("t5_valid_after", 264'(lane_valid), 264'(3'b111));
    chk("t5_d1_after", 264'(original_data_1[263:256]), 264'(8'hA1));

    // Back-to-back single-byte messages
    do_reset();
    np = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 8'(i + 1), 1, 0);
      if (message_en_out && np < 4) begin
        pc[np] = cycle;
        chk("t6_d1", 264'(original_data_1[263:256]), 264'(8'(3*np + 1)));
        chk("t6_d2", 264'(original_data_2[263:256]), 264'(8'(3*np + 2)));
        chk("t6_d3", 264'(original_data_3[263:256]), 264'(8'(3*np + 3)));
        np++;
      end
    end
    chk("t6_pulses", 264'(np), 264'(2));
    if (np == 2) chk("t6_spacing", 264'(pc[1] - pc[0]), 264'(3));

    // Random traffic
    do_reset();
    for (int m = 0; m < 300; m++) begin
      if ($urandom_range(99) < 2) do_reset();
      len  = ($urandom_range(9) == 0) ? int'($urandom_range(40, 33)) : int'($urandom_range(8, 1));
      fpos = ($urandom_range(19) == 0) ? int'($urandom_range(len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
        tick(1, 8'($urandom), i == len - 1, i == fpos);
        if (i == fpos) break;
        if ($urandom_range(9) == 0 && i != len - 1) tick(0, 8'h00, 0, 0);
      end
      gap = ($urandom_range(9) == 0) ? int'($urandom_range(20, 14)) : int'($urandom_range(2));
      for (int g = 0; g < gap; g++) tick(0, 8'h00, 0, $urandom_range(49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage1_assemble_module.md
Name: stage1_assemble_module

Overview:
Front-end stage that feeds stage2345_module. Takes a byte-serial market-data message stream and packs each message MSB-first into a 264-bit original_data word. Groups three consecutive messages into lanes 1..3 and presents them together with a one-cycle message_en_out pulse. Double-buffered, so assembly of the next group continues while a group is presented. No backpressure is required.

Parameters:
DATA_BYTES, 33, maximum message length in bytes (264 bits = `MAX_ORIGINAL_DATA_BITS / 8)
IDLE_TIMEOUT, 255, idle cycles with a partial group before forced emit; 0 disables the timeout
CNT_BITS, 8, width of the idle timeout counter (must hold IDLE_TIMEOUT)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
byte_in  input  8  message byte
byte_valid  input  1  byte_in valid this cycle
byte_last  input  1  qualifies the final byte of a message; ignored unless byte_valid=1
flush  input  1  force emit of completed lanes
message_en_out  output  1  one-cycle pulse; group valid
lane_valid  output  3  bit i set = original_data_(i+1) holds a message
original_data_1  output  264  lane 1 message, zero padded
original_data_2  output  264  lane 2 message, zero padded
original_data_3  output  264  lane 3 message, zero padded
overflow_err  output  1  one-cycle pulse; an overlength message was dropped

Behaviour:
- Reset: all outputs 0, assembly buffers 0, lane index 0, byte count 0, timeout counter 0, state IDLE.
- Packing: byte k (0-based) of a message goes to bits [263-8k -: 8] of the lane buffer. Unwritten bits stay 0. The lane buffer is cleared when its message starts.
- States:
  - IDLE: no open message, no completed lanes. byte_valid -> FILL.
  - FILL: message open. byte_last -> lane done, then:
    - if lane index was 2: emit, go to IDLE;
    - otherwise: lane index +1, go to WAIT.
    - A byte accepted while byte count = DATA_BYTES -> DROP.
  - WAIT: one or more completed lanes, no open message. byte_valid -> FILL. Idle timer counts while byte_valid=0.
  - DROP: discard bytes until byte_last inclusive. Pulse overflow_err on the cycle after the DROP->next transition. Return to WAIT if the lane index > 0, otherwise IDLE. The dropped message does not consume a lane.
- A single-byte message (byte_valid & byte_last in the same cycle from IDLE/WAIT) is legal and completes the lane immediately.
- Emit: copy all three lane buffers to the output registers. Lanes at or above the current lane index are forced to zero. Set lane_valid accordingly. message_en_out=1 for exactly one cycle.
- Latency: 1 cycle from the accepted byte_last of lane 3 to message_en_out.
- Output data and lane_valid hold until the next emit. message_en_out returns to 0.
- Back-to-back: byte_valid may be high every cycle. The first byte of the next group is accepted in the cycle after the emitting byte_last with no bubble.
- Timeout: in WAIT, after IDLE_TIMEOUT consecutive cycles with byte_valid=0, emit the partial group and go to IDLE. The counter clears on any byte_valid and on emit.
- Flush:
  - If completed lanes exist, emit them.
  - An open FILL/DROP message is discarded; no overflow_err for a flushed DROP.
  - Go to IDLE. Flush with no completed lanes: no pulse, go to IDLE.
- Simultaneous flush and byte_valid: the byte is processed first.
  - If it is the byte_last of lane 3, exactly one emit occurs, with 3'b111.
  - If it is a byte_last of lane 1 or 2, that lane is included in the flush emit.
  - If it is a non-final byte, the message is discarded.
- Reset mid-operation discards all state. The next message lands in lane 1.

Optional Feature:
STAGE1_MSG_COUNT_EN:
- When defined, adds output ports msg_cnt[31:0] and drop_cnt[31:0].
  - msg_cnt increments by popcount(lane_valid) on each emit.
  - drop_cnt increments on each overflow_err pulse.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent; other behaviour is identical.

Test Plan:
- Three messages: 41 4E 4E FF, then 41 4E 53, then 00, byte_last on each final byte -> one cycle after the final 00: message_en_out=1, lane_valid=3'b111, original_data_1[263:232]=32'h414E4EFF, original_data_2[263:240]=24'h414E53, original_data_3=0, all lower bits 0.
- 34-byte message, then a 2-byte message AB CD -> overflow_err pulse once, no emit. The next message occupies lane 1: after two more messages, original_data_1[263:248]=16'hABCD.
- IDLE_TIMEOUT=16: one message 55 55, then idle -> message_en_out on the 16th idle cycle, lane_valid=3'b001, data_2=data_3=0.
- Two complete messages, then 3 bytes of a third, then flush -> emit with lane_valid=3'b011. The next 1-byte message 77 starts lane 1 at bits [263:256]=8'h77.
- rst pulse mid-message after 1 complete lane -> all outputs 0. The following three messages emit with lane_valid=3'b111 and the first in lane 1.
- Six 1-byte messages 01..06 on consecutive cycles -> two message_en_out pulses 3 cycles apart. Lanes hold 01/02/03, then 04/05/06, in [263:256].
